// File: rtl/leaf_out_scheduler_if.sv
// Stream/packet interface between user output streams, the scheduler and the BFT side.
interface leaf_out_scheduler_if #(
    parameter int unsigned NUM_OUT_PORTS = 3,
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned PACKET_BITS   = 49
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    logic                                  out_ready;
    logic                                  resend;
    logic [PACKET_BITS-1:0]                dout_pkt;

    // User kernels and BFT side
    modport master (
        output din_leaf_user2interface,
        output vld_user2interface,
        output out_ready,
        output resend,
        input  ack_interface2user,
        input  dout_pkt
    );

    // Scheduler
    modport slave (
        input  din_leaf_user2interface,
        input  vld_user2interface,
        input  out_ready,
        input  resend,
        output ack_interface2user,
        output dout_pkt
    );
endinterface

// File: rtl/leaf_out_scheduler.sv
// Round-robin, credit-gated scheduler from user output streams onto the leaf packet bus.
module leaf_out_scheduler #(
    parameter int unsigned PACKET_BITS   = 49,
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned NUM_LEAF_BITS = 5,
    parameter int unsigned NUM_PORT_BITS = 4,
    parameter int unsigned NUM_ADDR_BITS = 7,
    parameter int unsigned NUM_OUT_PORTS = 3,
    parameter int unsigned INIT_CREDIT   = 128
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    leaf_out_scheduler_if.slave                    bus,
    input  logic                                   credit_vld,
    input  logic [2:0]                             credit_port,
    input  logic [NUM_ADDR_BITS:0]                 credit_amt,
    input  logic                                   cfg_wr,
    input  logic [2:0]                             cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS:0]   cfg_data,
    output logic                                   credit_err
);
    localparam int unsigned CW = NUM_ADDR_BITS + 1;  // credit counter width
    localparam int unsigned SW = CW + 1;             // credit sum width, holds INIT_CREDIT + max return
    localparam int unsigned DW = NUM_LEAF_BITS + NUM_PORT_BITS;

    logic                     enable_q [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
    logic [2:0]               rr_ptr_q;

    logic [NUM_OUT_PORTS-1:0] elig_c;
    logic [NUM_OUT_PORTS-1:0] ack_c;
    logic [NUM_OUT_PORTS-1:0] ovf_c;
    logic                     gnt_vld_c;
    logic [2:0]               gnt_idx_c;
    logic [PACKET_BITS-1:0]   pkt_d;
    logic [SW-1:0]            sum_c;

    // Per-port eligibility: enabled, valid and holding at least one credit
    always_comb begin
        for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
            elig_c[i] = enable_q[i] & bus.vld_user2interface[i] & (credit_q[i] != '0);
        end
    end

    // First eligible port scanning upward from rr_ptr, wrapping; frozen by resend or backpressure
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        if (bus.out_ready && !bus.resend) begin
            for (int k = 0; k < int'(NUM_OUT_PORTS); k++) begin
                for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
                    if (!gnt_vld_c && elig_c[i] &&
                        (i == (int'(rr_ptr_q) + k) % int'(NUM_OUT_PORTS))) begin
                        gnt_vld_c = 1'b1;
                        gnt_idx_c = 3'(i);
                    end
                end
            end
        end
    end

    // One-hot ack and the packet for the granted port, using the pre-update dest/addr
    always_comb begin
        ack_c = '0;
        pkt_d = '0;
        for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
            ack_c[i] = gnt_vld_c && (gnt_idx_c == 3'(i));
            if (ack_c[i]) begin
                pkt_d = {1'b1, leaf_q[i], dport_q[i], addr_q[i],
                         bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
            end
        end
    end

    assign bus.ack_interface2user = ack_c;

    // Next credit: current + return - grant, saturating at INIT_CREDIT
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
            sum_c = SW'(credit_q[i])
                  + ((credit_vld && (credit_port == 3'(i))) ? SW'(credit_amt) : SW'(0))
                  - SW'(ack_c[i]);
            ovf_c[i]    = sum_c > SW'(INIT_CREDIT);
            credit_d[i] = ovf_c[i] ? CW'(INIT_CREDIT) : CW'(sum_c);
        end
    end

    // Per-port credit, address and configuration state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
                enable_q[i] <= 1'b0;
                leaf_q[i]   <= '0;
                dport_q[i]  <= '0;
                addr_q[i]   <= '0;
                credit_q[i] <= CW'(INIT_CREDIT);
            end
        end else begin
            for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
                credit_q[i] <= credit_d[i];
                if (ack_c[i]) begin
                    addr_q[i] <= addr_q[i] + 1'b1;
                end
                if (cfg_wr && (cfg_port == 3'(i))) begin
                    enable_q[i] <= cfg_data[DW];
                    leaf_q[i]   <= cfg_data[DW-1 -: NUM_LEAF_BITS];
                    dport_q[i]  <= cfg_data[NUM_PORT_BITS-1:0];
                end
            end
        end
    end

    // Round-robin pointer moves past the granted port only on a grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (gnt_vld_c) begin
            rr_ptr_q <= (gnt_idx_c == 3'(NUM_OUT_PORTS - 1)) ? 3'd0 : gnt_idx_c + 3'd1;
        end
    end

    // Registered packet output and sticky credit overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.dout_pkt <= '0;
            credit_err   <= 1'b0;
        end else begin
            bus.dout_pkt <= pkt_d;
            if (|ovf_c) begin
                credit_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_leaf_out_scheduler.sv
// Randomized self-checking bench for leaf_out_scheduler against a behavioural model.
module tb_leaf_out_scheduler;
    localparam int NP   = 3;
    localparam int INIT = 128;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       credit_vld;
    logic [2:0] credit_port;
    logic [7:0] credit_amt;
    logic       cfg_wr;
    logic [2:0] cfg_port;
    logic [9:0] cfg_data;
    logic       credit_err;

    always #5 clk = ~clk;

    leaf_out_scheduler_if #(.NUM_OUT_PORTS(3), .PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

    leaf_out_scheduler #(
        .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5), .NUM_PORT_BITS(4),
        .NUM_ADDR_BITS(7), .NUM_OUT_PORTS(3), .INIT_CREDIT(128)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .credit_vld(credit_vld), .credit_port(credit_port), .credit_amt(credit_amt),
        .cfg_wr(cfg_wr), .cfg_port(cfg_port), .cfg_data(cfg_data),
        .credit_err(credit_err)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int    m_en [NP];
    int    m_leaf [NP];
    int    m_dport [NP];
    int    m_addr [NP];
    int    m_cr [NP];
    int    m_rr;
    bit    m_err;
    int    m_gnt;
    logic [2:0]  exp_ack;
    logic [48:0] exp_pkt;

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_en[i] = 0; m_leaf[i] = 0; m_dport[i] = 0; m_addr[i] = 0; m_cr[i] = INIT;
        end
        m_rr = 0; m_err = 1'b0; m_gnt = -1;
    endtask

    // Evaluate the current inputs: expected ack now, expected packet after the edge, then advance state
    task automatic model_eval();
        int g;
        int p;
        g = -1;
        exp_ack = '0;
        exp_pkt = '0;
        if (bus.out_ready && !bus.resend) begin
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (m_rr + k) % NP;
                if (g < 0 && m_en[i] != 0 && bus.vld_user2interface[i] && m_cr[i] > 0) g = i;
            end
        end
        m_gnt = g;
        if (g >= 0) begin
            exp_ack = 3'(1 << g);
            exp_pkt = {1'b1, 5'(m_leaf[g]), 4'(m_dport[g]), 7'(m_addr[g]),
                       bus.din_leaf_user2interface[g*32 +: 32]};
            m_addr[g] = (m_addr[g] + 1) % 128;
            m_cr[g]   = m_cr[g] - 1;
            m_rr      = (g + 1) % NP;
        end
        if (credit_vld && int'(credit_port) < NP) begin
            p = int'(credit_port);
            m_cr[p] = m_cr[p] + int'(credit_amt);
            if (m_cr[p] > INIT) begin
                m_cr[p] = INIT;
                m_err   = 1'b1;
            end
        end
        if (cfg_wr && int'(cfg_port) < NP) begin
            p = int'(cfg_port);
            m_en[p]    = int'(cfg_data[9]);
            m_leaf[p]  = int'(cfg_data[8:4]);
            m_dport[p] = int'(cfg_data[3:0]);
        end
    endtask

    task automatic drive_idle();
        bus.vld_user2interface      = '0;
        bus.din_leaf_user2interface = {$urandom, $urandom, $urandom};
        bus.out_ready = 1'b1;
        bus.resend    = 1'b0;
        credit_vld = 1'b0; credit_port = '0; credit_amt = '0;
        cfg_wr = 1'b0; cfg_port = '0; cfg_data = '0;
    endtask

    // Setup cycle: model follows the DUT but nothing is compared
    task automatic advance();
        #1; model_eval();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic cfg_cycle(input int port, input int en, input int leaf, input int dport);
        drive_idle();
        cfg_wr = 1'b1; cfg_port = 3'(port);
        cfg_data = {1'(en), 5'(leaf), 4'(dport)};
        advance();
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        #1;
        checks++; if (bus.dout_pkt !== 49'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus.dout_pkt); end
        checks++; if (bus.ack_interface2user !== 3'b000) begin errors++; $display("FAIL reset_ack got=%b exp=000", bus.ack_interface2user); end
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", credit_err); end
        @(negedge clk); reset_n = 1'b1;
        bus.vld_user2interface = 3'b111;
        #1; model_eval();
        checks++; if (bus.ack_interface2user !== exp_ack) begin errors++; $display("FAIL disabled_ack got=%b exp=%b", bus.ack_interface2user, exp_ack); end
        @(posedge clk); #1;
        checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL disabled_dout got=%h exp=%h", bus.dout_pkt, exp_pkt); end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [48:0] golden;
        golden = {1'b1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF};
        cfg_cycle(0, 1, 5, 2);
        bus.vld_user2interface = 3'b001;
        bus.din_leaf_user2interface[31:0] = 32'hDEADBEEF;
        #1; model_eval();
        checks++; if (bus.ack_interface2user !== 3'b001) begin errors++; $display("FAIL single_ack got=%b exp=001", bus.ack_interface2user); end
        @(posedge clk); #1;
        checks++; if (bus.dout_pkt !== golden) begin errors++; $display("FAIL single_pkt got=%h exp=%h", bus.dout_pkt, golden); end
        @(negedge clk);
        drive_idle();
        #1; model_eval();
        @(posedge clk); #1;
        checks++; if (bus.dout_pkt !== 49'd0) begin errors++; $display("FAIL single_idle got=%h exp=0", bus.dout_pkt); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int start;
        cfg_cycle(1, 1, 3, 7);
        cfg_cycle(2, 1, 17, 9);
        start = m_rr;
        for (int n = 0; n < 9; n++) begin
            bus.vld_user2interface = 3'b111;
            bus.din_leaf_user2interface = {$urandom, $urandom, $urandom};
            #1; model_eval();
            checks++; if (bus.ack_interface2user !== 3'(1 << ((start + n) % NP))) begin errors++; $display("FAIL rr_order cyc=%0d got=%b exp_port=%0d", n, bus.ack_interface2user, (start + n) % NP); end
            @(posedge clk); #1;
            checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL rr_pkt cyc=%0d got=%h exp=%h", n, bus.dout_pkt, exp_pkt); end
            @(negedge clk);
        end
    endtask

    task automatic test_credit_exhaust();
        int start_cr;
        int seen1;
        start_cr = m_cr[1];
        seen1 = 0;
        for (int n = 0; n < 420; n++) begin
            drive_idle();
            bus.vld_user2interface = 3'b111;
            if (m_cr[(n % 2) * 2] < 120) begin
                credit_vld = 1'b1; credit_port = 3'((n % 2) * 2); credit_amt = 8'd1;
            end
            #1; model_eval();
            checks++; if (bus.ack_interface2user !== exp_ack) begin errors++; $display("FAIL exh_ack cyc=%0d got=%b exp=%b", n, bus.ack_interface2user, exp_ack); end
            if (bus.ack_interface2user[1]) seen1++;
            @(posedge clk); #1;
            checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL exh_pkt cyc=%0d got=%h exp=%h", n, bus.dout_pkt, exp_pkt); end
            @(negedge clk);
        end
        checks++; if (seen1 !== start_cr) begin errors++; $display("FAIL exh_count got=%0d exp=%0d", seen1, start_cr); end
        drive_idle();
        credit_vld = 1'b1; credit_port = 3'd1; credit_amt = 8'd4;
        advance();
        seen1 = 0;
        for (int n = 0; n < 30; n++) begin
            drive_idle();
            bus.vld_user2interface = 3'b111;
            #1; model_eval();
            checks++; if (bus.ack_interface2user !== exp_ack) begin errors++; $display("FAIL ret_ack cyc=%0d got=%b exp=%b", n, bus.ack_interface2user, exp_ack); end
            if (bus.ack_interface2user[1]) seen1++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        checks++; if (seen1 !== 4) begin errors++; $display("FAIL ret_count got=%0d exp=4", seen1); end
    endtask

    task automatic test_addr_wrap();
        bit seen_wrap;
        int prev;
        seen_wrap = 1'b0;
        prev = -1;
        for (int n = 0; n < 130; n++) begin
            drive_idle();
            bus.vld_user2interface = 3'b001;
            if (m_cr[0] < INIT - 1) begin
                credit_vld = 1'b1; credit_port = 3'd0; credit_amt = 8'd1;
            end
            #1; model_eval();
            checks++; if (bus.ack_interface2user !== exp_ack) begin errors++; $display("FAIL wrap_ack cyc=%0d got=%b exp=%b", n, bus.ack_interface2user, exp_ack); end
            @(posedge clk); #1;
            checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL wrap_pkt cyc=%0d got=%h exp=%h", n, bus.dout_pkt, exp_pkt); end
            if (bus.dout_pkt[48]) begin
                if (prev == 127 && bus.dout_pkt[38:32] == 7'd0) seen_wrap = 1'b1;
                prev = int'(bus.dout_pkt[38:32]);
            end
            @(negedge clk);
        end
        checks++; if (seen_wrap !== 1'b1) begin errors++; $display("FAIL wrap_seen got=%b exp=1", seen_wrap); end
    endtask

    task automatic test_resend();
        drive_idle();
        credit_vld = 1'b1; credit_port = 3'd1; credit_amt = 8'd8;
        advance();
        for (int n = 0; n < 11; n++) begin
            drive_idle();
            bus.vld_user2interface = 3'b111;
            bus.resend = (n < 5);
            #1; model_eval();
            checks++; if (bus.ack_interface2user !== exp_ack) begin errors++; $display("FAIL resend_ack cyc=%0d got=%b exp=%b", n, bus.ack_interface2user, exp_ack); end
            @(posedge clk); #1;
            checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL resend_pkt cyc=%0d got=%h exp=%h", n, bus.dout_pkt, exp_pkt); end
            if (n < 5) begin
                checks++; if (bus.dout_pkt !== 49'd0) begin errors++; $display("FAIL resend_zero cyc=%0d got=%h exp=0", n, bus.dout_pkt); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_credit_err();
        drive_idle();
        if (m_cr[2] < INIT) begin
            credit_vld = 1'b1; credit_port = 3'd2; credit_amt = 8'(INIT - m_cr[2]);
        end
        advance();
        drive_idle();
        bus.vld_user2interface = 3'b100;
        advance();
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL err_pre got=%b exp=0", credit_err); end
        drive_idle();
        bus.vld_user2interface = 3'b100;
        credit_vld = 1'b1; credit_port = 3'd2; credit_amt = 8'd10;
        #1; model_eval();
        checks++; if (bus.ack_interface2user !== 3'b100) begin errors++; $display("FAIL err_ack got=%b exp=100", bus.ack_interface2user); end
        @(posedge clk); #1;
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", credit_err); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive_idle();
            bus.vld_user2interface = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.resend    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) begin
                credit_vld = 1'b1; credit_port = 3'($urandom_range(0, 7)); credit_amt = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 19) == 0) begin
                cfg_wr = 1'b1; cfg_port = 3'($urandom_range(0, 7));
                cfg_data = {1'($urandom_range(0, 3) != 0), 9'($urandom)};
            end
            #1; model_eval();
            checks++; if (bus.ack_interface2user !== exp_ack) begin errors++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", n, bus.ack_interface2user, exp_ack); end
            @(posedge clk); #1;
            checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL rand_pkt cyc=%0d got=%h exp=%h", n, bus.dout_pkt, exp_pkt); end
            checks++; if (credit_err !== m_err) begin errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", n, credit_err, m_err); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < NP; p++) begin
            cfg_cycle(p, 1, p + 1, p + 2);
            credit_vld = 1'b1; credit_port = 3'(p); credit_amt = 8'd20;
            advance();
        end
        for (int n = 0; n < 3; n++) begin
            drive_idle();
            bus.vld_user2interface = 3'b111;
            #1; model_eval();
            @(posedge clk); #1;
            checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL burst_pkt cyc=%0d got=%h exp=%h", n, bus.dout_pkt, exp_pkt); end
            @(negedge clk);
        end
        drive_idle();
        bus.vld_user2interface = 3'b111;
        #2; reset_n = 1'b0;
        #1;
        checks++; if (bus.dout_pkt !== 49'd0) begin errors++; $display("FAIL arst_dout got=%h exp=0", bus.dout_pkt); end
        checks++; if (bus.ack_interface2user !== 3'b000) begin errors++; $display("FAIL arst_ack got=%b exp=000", bus.ack_interface2user); end
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL arst_err got=%b exp=0", credit_err); end
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        #1; model_eval();
        @(posedge clk); #1;
        checks++; if (bus.dout_pkt !== exp_pkt) begin errors++; $display("FAIL post_arst_pkt got=%h exp=%h", bus.dout_pkt, exp_pkt); end
        @(negedge clk);
    endtask

    initial begin
        drive_idle();
        model_reset();
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_credit_exhaust();
        test_addr_wrap();
        test_resend();
        test_credit_err();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/leaf_out_scheduler.md
Name: leaf_out_scheduler

Overview:
- Sits inside a leaf shell between the user-kernel output streams and the 49-bit packet bus toward the BFT.
- Arbitrates NUM_OUT_PORTS user output streams (valid/ack, 32-bit payload) round-robin.
- Gates each stream on per-port credits that mirror free space in the destination BRAM.
- Stamps each word with a configurable destination leaf/port and a wrapping address, and emits at most one packet per cycle.

Parameters:
- PACKET_BITS, 49: output packet width; equals 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS.
- PAYLOAD_BITS, 32: user data width.
- NUM_LEAF_BITS, 5: destination leaf field width.
- NUM_PORT_BITS, 4: destination port field width.
- NUM_ADDR_BITS, 7: address field width; the address counter wraps modulo 2^NUM_ADDR_BITS.
- NUM_OUT_PORTS, 3: number of user output streams (1..8).
- INIT_CREDIT, 128: credit value after reset; must be at most 2^NUM_ADDR_BITS.

Ports:
- clk, input, 1: single clock.
- reset_n, input, 1: asynchronous, active-low reset.
- din_leaf_user2interface, input, NUM_OUT_PORTS*PAYLOAD_BITS: per-port payload; port i occupies slice i.
- vld_user2interface, input, NUM_OUT_PORTS: per-port valid.
- ack_interface2user, output, NUM_OUT_PORTS: per-port ack (combinational); a transfer occurs when vld & ack.
- out_ready, input, 1: BFT side can accept a packet this cycle.
- resend, input, 1: freezes all grants while high.
- dout_pkt, output, PACKET_BITS: registered packet.
- credit_vld, input, 1: credit return strobe.
- credit_port, input, 3: port index of the credit return.
- credit_amt, input, NUM_ADDR_BITS+1: number of credits returned.
- cfg_wr, input, 1: config write strobe.
- cfg_port, input, 3: port index of the config write.
- cfg_data, input, 1+NUM_LEAF_BITS+NUM_PORT_BITS: {enable, dest_leaf, dest_port}.
- credit_err, output, 1: sticky flag for a credit return that overflowed.

Behaviour:
- Reset (async assert, sync release):
  - dout_pkt = 0, all ack = 0, credit_err = 0.
  - Credits = INIT_CREDIT; address counters = 0; round-robin pointer = 0; all ports disabled with dest fields 0.
- Eligibility: port i is eligible when enable_i = 1, vld_i = 1 and credit_i > 0.
- Grant:
  - Allowed only when out_ready = 1 and resend = 0.
  - Choose the first eligible port scanning from rr_ptr upward, wrapping.
  - ack_i = 1 for the granted port only; at most one ack is high per cycle.
  - A port's ack is never high unless its vld is high.
- On grant of port g:
  - Next cycle, dout_pkt = {1'b1, dest_leaf_g, dest_port_g, addr_g, payload_g}. Latency is exactly one cycle.
  - addr_g increments by 1, wrapping from 2^NUM_ADDR_BITS-1 to 0.
  - credit_g decrements by 1.
  - rr_ptr becomes (g+1) mod NUM_OUT_PORTS.
- No grant in a cycle: next cycle dout_pkt = 0 (bit 48 = 0) and rr_ptr is unchanged.
- resend high: no grant. The cycle after resend first rises, dout_pkt is 0. Arbitration resumes the cycle resend falls, with state preserved.
- Credit return:
  - credit_port credit += credit_amt.
  - If the result would exceed INIT_CREDIT, saturate at INIT_CREDIT and set credit_err. credit_err clears only on reset.
  - Decrement and return on the same port in the same cycle: net = credit - 1 + credit_amt, then saturate.
  - A credit_port or cfg_port value of NUM_OUT_PORTS or more is ignored.
- Config write:
  - Updates enable and dest fields for cfg_port; takes effect from the next cycle.
  - Writing cfg to the port granted in the same cycle does not alter that cycle's packet, which uses the old dest.
  - Disabling a port leaves its credit and address counters unchanged.
- credit = 0 on a port: that port is skipped and the grant passes to the next eligible port; no stall.
- Width rule: credit counters are NUM_ADDR_BITS+1 bits wide, unsigned.

Test Plan:
- Reset then enable port 0 (leaf 5, port 2) and send payload 0xDEADBEEF. One cycle after ack, dout_pkt = {1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF}; addr_0 = 1; credit_0 = 127.
- All 3 ports enabled and continuously valid for 9 cycles. Grant order is 0,1,2,0,1,2,0,1,2; exactly one ack per cycle; no gaps in dout_pkt.
- Port 1 sends 128 words with no credit return. Ack_1 stays low from word 129 while ports 0 and 2 continue. Return credit_amt = 4 → exactly 4 further grants on port 1.
- Send 130 words on one port with ample credit returns. Address field sequence is ...,126,127,0,1.
- Hold resend high for 5 cycles with all ports valid. No ack and dout_pkt = 0 throughout; after resend falls, the grant continues from the saved rr_ptr.
- At credit = 127, a same-cycle grant plus return of 10 → credit = 128 and credit_err = 1. Assert reset_n low mid-burst → dout_pkt = 0 and ack = 0 immediately, without waiting for a clock edge.
